pwm_deadtime_gen: RTL and testbench

//  Downstream stage of the PWM generator. Turns the single pwm_out stream into a

---
 rtl/pwm_deadtime_gen.sv | 153 +++++++++++++++
 tb/tb_pwm_deadtime_gen.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/pwm_deadtime_gen.sv
// pwm_deadtime_gen: complementary half-bridge drive from pwm_in with programmable dead time on each edge.
// Outputs registered one edge after pwm_in is sampled; no backpressure. Optional fault latch: PWM_DT_FAULT_EN.
module pwm_deadtime_gen #(
  parameter int DT_WIDTH = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                dt_en,
  input  logic                pwm_in,
  input  logic [DT_WIDTH-1:0] dt_rise,
  input  logic [DT_WIDTH-1:0] dt_fall,
`ifdef PWM_DT_FAULT_EN
  input  logic                fault_in,
  input  logic                fault_clr,
  output logic                fault_latched,
`endif
  output logic                pwm_hi,
  output logic                pwm_lo,
  output logic                dt_active
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    HI_ON = 3'd1,
    LO_ON = 3'd2,
    DT_HL = 3'd3,
    DT_LH = 3'd4,
    FAULT = 3'd5
  } state_t;

  localparam logic [DT_WIDTH-1:0] CNT_ZERO = '0;
  localparam logic [DT_WIDTH-1:0] CNT_ONE  = DT_WIDTH'(1);

  state_t              state_q, state_d;
  logic [DT_WIDTH-1:0] cnt_q, cnt_d;
  logic                hi_q, lo_q, dta_q;

`ifdef PWM_DT_FAULT_EN
  logic sync1_q, sync2_q, fault_q;

  // fault_in may come from another domain; only sync2_q feeds the FSM
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= fault_in;
      sync2_q <= sync1_q;
    end
  end
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
`ifdef PWM_DT_FAULT_EN
    if (sync2_q) begin
      state_d = FAULT;
      cnt_d   = CNT_ZERO;
    end else if (state_q == FAULT) begin
      if (fault_clr) state_d = IDLE;
    end else
`endif
    if (!dt_en) begin
      state_d = IDLE;
      cnt_d   = CNT_ZERO;
    end else begin
      case (state_q)
        IDLE: begin
          state_d = pwm_in ? HI_ON : LO_ON;
        end
        LO_ON: begin
          if (pwm_in) begin
            if (dt_rise == CNT_ZERO) begin
              state_d = HI_ON;
            end else begin
              state_d = DT_LH;
              cnt_d   = dt_rise;
            end
          end
        end
        HI_ON: begin
          if (!pwm_in) begin
            if (dt_fall == CNT_ZERO) begin
              state_d = LO_ON;
            end else begin
              state_d = DT_HL;
              cnt_d   = dt_fall;
            end
          end
        end
        // A request that reverts mid-count returns to the side already driving
        DT_LH: begin
          if (!pwm_in) begin
            state_d = LO_ON;
            cnt_d   = CNT_ZERO;
          end else if (cnt_q == CNT_ONE) begin
            state_d = HI_ON;
            cnt_d   = CNT_ZERO;
          end else begin
            cnt_d = cnt_q - CNT_ONE;
          end
        end
        DT_HL: begin
          if (pwm_in) begin
            state_d = HI_ON;
            cnt_d   = CNT_ZERO;
          end else if (cnt_q == CNT_ONE) begin
            state_d = LO_ON;
            cnt_d   = CNT_ZERO;
          end else begin
            cnt_d = cnt_q - CNT_ONE;
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = CNT_ZERO;
        end
      endcase
    end
  end

  // Outputs are decoded from next state so they line up with state_q
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= CNT_ZERO;
      hi_q    <= 1'b0;
      lo_q    <= 1'b0;
      dta_q   <= 1'b0;
`ifdef PWM_DT_FAULT_EN
      fault_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hi_q    <= (state_d == HI_ON);
      lo_q    <= (state_d == LO_ON);
      dta_q   <= (state_d == DT_HL) || (state_d == DT_LH);
`ifdef PWM_DT_FAULT_EN
      fault_q <= (state_d == FAULT);
`endif
    end
  end

  assign pwm_hi    = hi_q;
  assign pwm_lo    = lo_q;
  assign dt_active = dta_q;
`ifdef PWM_DT_FAULT_EN
  assign fault_latched = fault_q;
`endif

endmodule

// File: tb/tb_pwm_deadtime_gen.sv
// Bench for pwm_deadtime_gen: directed vectors with literal expectations plus a
// run-length behavioural model checked on every falling clock edge.
module tb_pwm_deadtime_gen;

  localparam logic [2:0] OFF = 3'b000;
  localparam logic [2:0] HI  = 3'b100;
  localparam logic [2:0] LO  = 3'b010;
  localparam logic [2:0] DT  = 3'b001;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       dt_en = 1'b0;
  logic       pwm_in = 1'b0;
  logic [7:0] dt_rise = 8'd3;
  logic [7:0] dt_fall = 8'd2;
  logic       pwm_hi, pwm_lo, dt_active;
`ifdef PWM_DT_FAULT_EN
  logic       fault_in = 1'b0;
  logic       fault_clr = 1'b0;
  logic       fault_latched;
  logic       lit_fl = 1'b0;
`endif

  pwm_deadtime_gen #(.DT_WIDTH(8)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .dt_en(dt_en),
    .pwm_in(pwm_in),
    .dt_rise(dt_rise),
    .dt_fall(dt_fall),
`ifdef PWM_DT_FAULT_EN
    .fault_in(fault_in),
    .fault_clr(fault_clr),
    .fault_latched(fault_latched),
`endif
    .pwm_hi(pwm_hi),
    .pwm_lo(pwm_lo),
    .dt_active(dt_active)
  );

  always #5 clk = ~clk;

  // Model: which side owns the bridge (0 none, 1 hi, 2 lo) and how many consecutive
  // samples have asked for the other side; a run longer than the dead time latched
  // at its first sample hands the bridge over.
  typedef struct {
    int side;
    int run;
    int dt;
  } mst_t;

  mst_t m = '{0, 0, 0};

  function automatic mst_t mstep(mst_t s, logic en, logic pin, logic [7:0] r, logic [7:0] f);
    mst_t n = s;
    int want;
    if (!en) begin
      n.side = 0;
      n.run  = 0;
      return n;
    end
    if (s.side == 0) begin
      n.side = pin ? 1 : 2;
      n.run  = 0;
      return n;
    end
    want = pin ? 1 : 2;
    if (want == s.side) begin
      n.run = 0;
      return n;
    end
    n.run = s.run + 1;
    if (n.run == 1) n.dt = pin ? int'(r) : int'(f);
    if (n.run > n.dt) begin
      n.side = want;
      n.run  = 0;
    end
    return n;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) m <= '{0, 0, 0};
    else        m <= mstep(m, dt_en, pwm_in, dt_rise, dt_fall);
  end

  int    n_cmp = 0;
  int    n_bad = 0;
  logic  chk_model = 1'b1;
  logic  rst_probe = 1'b0;
  logic  lit_vld = 1'b0;
  logic  [2:0] lit_exp = OFF;
  string lit_name = "none";

  task cmp(input string nm, input int act, input int exp);
    n_cmp = n_cmp + 1;
    if (act != exp) begin
      n_bad = n_bad + 1;
      $display("FAIL %s: got %0d, expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk or posedge rst_probe) begin
    if (chk_model) begin
      cmp("model_hi",  int'(pwm_hi),    int'(m.side == 1 && m.run == 0));
      cmp("model_lo",  int'(pwm_lo),    int'(m.side == 2 && m.run == 0));
      cmp("model_dta", int'(dt_active), int'(m.run > 0));
    end
    cmp("no_overlap", int'(pwm_hi & pwm_lo), 0);
    if (lit_vld) begin
      cmp({lit_name, "_hi"},  int'(pwm_hi),    int'(lit_exp[2]));
      cmp({lit_name, "_lo"},  int'(pwm_lo),    int'(lit_exp[1]));
      cmp({lit_name, "_dta"}, int'(dt_active), int'(lit_exp[0]));
`ifdef PWM_DT_FAULT_EN
      cmp({lit_name, "_flt"}, int'(fault_latched), int'(lit_fl));
`endif
    end
  end

  // Drive one vector just after a falling edge; the result is checked at the next one.
  task automatic row(input logic pin, input logic en, input logic [7:0] r, input logic [7:0] f,
                     input logic [2:0] exp, input string nm);
    pwm_in   = pin;
    dt_en    = en;
    dt_rise  = r;
    dt_fall  = f;
    lit_vld  = 1'b1;
    lit_exp  = exp;
    lit_name = nm;
    @(negedge clk);
    #1;
  endtask

  initial begin
    #1;
    rst_n    = 1'b0;
    lit_vld  = 1'b1;
    lit_exp  = OFF;
    lit_name = "reset";
    @(negedge clk);
    #1;
    rst_n = 1'b1;

    // Scenario 1: rise 3, fall 2, period 16 with 8 high
    row(1'b0, 1'b1, 8'd3, 8'd2, LO, "s1_enable");
    for (int p = 0; p < 2; p++) begin
      for (int i = 0; i < 16; i++) begin
        if (i < 8) row(1'b1, 1'b1, 8'd3, 8'd2, (i < 3) ? DT : HI, "s1_high");
        else       row(1'b0, 1'b1, 8'd3, 8'd2, (i < 10) ? DT : LO, "s1_low");
      end
    end

    // Scenario 2: zero dead time swaps directly
    row(1'b1, 1'b1, 8'd0, 8'd0, HI, "s2_hi_a");
    row(1'b1, 1'b1, 8'd0, 8'd0, HI, "s2_hi_b");
    row(1'b0, 1'b1, 8'd0, 8'd0, LO, "s2_lo_a");
    row(1'b1, 1'b1, 8'd0, 8'd0, HI, "s2_hi_c");
    row(1'b0, 1'b1, 8'd0, 8'd0, LO, "s2_lo_b");

    // Scenario 3: pulse shorter than dead time never reaches hi
    row(1'b1, 1'b1, 8'd5, 8'd0, DT, "s3_dead1");
    row(1'b1, 1'b1, 8'd5, 8'd0, DT, "s3_dead2");
    row(1'b0, 1'b1, 8'd5, 8'd0, LO, "s3_back_lo");
    row(1'b0, 1'b1, 8'd5, 8'd0, LO, "s3_hold_lo");

    // Scenario 4: disable mid dead-time with counter at 3, then re-enable
    row(1'b1, 1'b1, 8'd5, 8'd0, DT, "s4_dead1");
    row(1'b1, 1'b1, 8'd5, 8'd0, DT, "s4_dead2");
    row(1'b1, 1'b1, 8'd5, 8'd0, DT, "s4_dead3");
    row(1'b1, 1'b0, 8'd5, 8'd0, OFF, "s4_disable");
    row(1'b0, 1'b0, 8'd5, 8'd0, OFF, "s4_idle");
    row(1'b0, 1'b1, 8'd5, 8'd0, LO, "s4_reenable");
    row(1'b0, 1'b0, 8'd5, 8'd2, OFF, "s4_idle2");
    row(1'b1, 1'b1, 8'd5, 8'd2, HI, "idle_to_hi");

    // Abort of hi->lo dead time, then a fall value changed mid-count
    row(1'b0, 1'b1, 8'd5, 8'd2, DT, "hl_dead");
    row(1'b1, 1'b1, 8'd5, 8'd2, HI, "hl_abort");
    row(1'b0, 1'b1, 8'd5, 8'd4, DT, "mid_dead1");
    row(1'b0, 1'b1, 8'd5, 8'd1, DT, "mid_dead2");
    row(1'b0, 1'b1, 8'd5, 8'd1, DT, "mid_dead3");
    row(1'b0, 1'b1, 8'd5, 8'd1, DT, "mid_dead4");
    row(1'b0, 1'b1, 8'd5, 8'd1, LO, "mid_done");

    // Single-cycle dead time both ways
    row(1'b1, 1'b1, 8'd1, 8'd1, DT, "rise1_dead");
    row(1'b1, 1'b1, 8'd1, 8'd1, HI, "rise1_hi");
    row(1'b0, 1'b1, 8'd1, 8'd1, DT, "fall1_dead");
    row(1'b0, 1'b1, 8'd1, 8'd1, LO, "fall1_lo");

    // Maximum dead time 255
    for (int i = 0; i < 255; i++) row(1'b1, 1'b1, 8'd255, 8'd0, DT, "max_dead");
    row(1'b1, 1'b1, 8'd255, 8'd0, HI, "max_hi");

    // Scenario 5: asynchronous reset in the middle of a dead time
    row(1'b0, 1'b1, 8'd0, 8'd5, DT, "pre_rst1");
    row(1'b0, 1'b1, 8'd0, 8'd5, DT, "pre_rst2");
    #1;
    rst_n = 1'b0;
    #1;
    lit_vld   = 1'b1;
    lit_exp   = OFF;
    lit_name  = "async_rst";
    rst_probe = 1'b1;
    @(negedge clk);
    #1;
    rst_probe = 1'b0;
    rst_n     = 1'b1;
    row(1'b0, 1'b1, 8'd0, 8'd5, LO, "post_rst");

`ifdef PWM_DT_FAULT_EN
    // Scenario 6: fault path, literal checks only
    chk_model = 1'b0;
    row(1'b1, 1'b1, 8'd0, 8'd0, HI, "f_pre");
    fault_in = 1'b1;
    row(1'b1, 1'b1, 8'd0, 8'd0, HI, "f_sync1");
    row(1'b1, 1'b1, 8'd0, 8'd0, HI, "f_sync2");
    lit_fl = 1'b1;
    row(1'b1, 1'b1, 8'd0, 8'd0, OFF, "f_trip");
    fault_clr = 1'b1;
    row(1'b1, 1'b1, 8'd0, 8'd0, OFF, "f_clr_blocked1");
    row(1'b1, 1'b1, 8'd0, 8'd0, OFF, "f_clr_blocked2");
    fault_in  = 1'b0;
    fault_clr = 1'b0;
    row(1'b1, 1'b1, 8'd0, 8'd0, OFF, "f_drain1");
    row(1'b1, 1'b1, 8'd0, 8'd0, OFF, "f_drain2");
    fault_clr = 1'b1;
    lit_fl    = 1'b0;
    row(1'b1, 1'b1, 8'd0, 8'd0, OFF, "f_exit");
    fault_clr = 1'b0;
    row(1'b1, 1'b1, 8'd0, 8'd0, HI, "f_resume");
`endif

    lit_vld = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
